// File: rtl/fmul_arb_if.sv
// Bundle of the two requester channels, the response channels and the
// shared-multiplier connection used by fmul_arb.
//   master : requester side (issues ops, consumes results)
//   slave  : the arbiter itself
//   mult   : the external combinational multiplier
// clk/rst are not carried here; they remain plain ports on the arbiter.
interface fmul_arb_if;
  // Requester A
  logic        a_valid;
  logic        a_ready;
  logic [31:0] a_x1;
  logic [31:0] a_x2;
  logic        a_rsp_valid;
  logic        a_rsp_ready;
  logic [31:0] a_y;
  // Requester B
  logic        b_valid;
  logic        b_ready;
  logic [31:0] b_x1;
  logic [31:0] b_x2;
  logic        b_rsp_valid;
  logic        b_rsp_ready;
  logic [31:0] b_y;
  // Shared multiplier
  logic [31:0] fm_x1;
  logic [31:0] fm_x2;
  logic [31:0] fm_y;
  // Status
  logic        busy;

  modport master (
    output a_valid, a_x1, a_x2, a_rsp_ready,
    output b_valid, b_x1, b_x2, b_rsp_ready,
    input  a_ready, a_rsp_valid, a_y,
    input  b_ready, b_rsp_valid, b_y,
    input  busy
  );

  modport slave (
    input  a_valid, a_x1, a_x2, a_rsp_ready,
    input  b_valid, b_x1, b_x2, b_rsp_ready,
    output a_ready, a_rsp_valid, a_y,
    output b_ready, b_rsp_valid, b_y,
    output fm_x1, fm_x2,
    input  fm_y,
    output busy
  );

  modport mult (
    input  fm_x1, fm_x2,
    output fm_y
  );
endinterface

// File: rtl/fmul_arb.sv
// fmul_arb: round-robin arbiter/sequencer sharing one combinational
// single-precision multiplier between requesters A and B.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : fmul_arb_if.slave -- request/response channels for A and B,
//          multiplier operands (fm_x1/fm_x2) and product (fm_y), busy.
// Pipeline: request handshake -> operand stage S1 (drives multiplier)
// -> per-requester response register. Results are bit-exact fm_y.
module fmul_arb #(
  parameter int RR_INIT = 0  // requester favoured after reset: 0 = A, 1 = B
) (
  input  logic       clk,
  input  logic       rst,
  fmul_arb_if.slave  bus
);

  // Operand stage
  logic        s1_valid;
  logic        s1_id;      // 0 = A, 1 = B
  logic [31:0] s1_x1;
  logic [31:0] s1_x2;

  // Response registers
  logic        rsp_valid_a;
  logic        rsp_valid_b;
  logic [31:0] y_a;
  logic [31:0] y_b;

  // Round-robin pointer: 0 favours A, 1 favours B
  logic        ptr;

  logic elig_a, elig_b;
  logic grant_a, grant_b;
  logic hs_a, hs_b;

  // A requester is eligible when it has no op in S1 (which would collide
  // with its own response slot) and its response slot is free or being
  // popped this cycle, so S1 always writes into a free slot.
  assign elig_a = !(s1_valid && !s1_id) && (!rsp_valid_a || bus.a_rsp_ready);
  assign elig_b = !(s1_valid &&  s1_id) && (!rsp_valid_b || bus.b_rsp_ready);

  // A takes the grant when favoured, or when B cannot use it. B only loses
  // if A both holds the grant and is actually requesting, so ready never
  // depends on the same port's valid.
  assign grant_a = elig_a && (!ptr || !bus.b_valid || !elig_b);
  assign grant_b = elig_b && !(grant_a && bus.a_valid);

  assign hs_a = bus.a_valid && grant_a;
  assign hs_b = bus.b_valid && grant_b;

  assign bus.a_ready     = grant_a;
  assign bus.b_ready     = grant_b;
  assign bus.fm_x1       = s1_x1;
  assign bus.fm_x2       = s1_x2;
  assign bus.a_rsp_valid = rsp_valid_a;
  assign bus.b_rsp_valid = rsp_valid_b;
  assign bus.a_y         = y_a;
  assign bus.b_y         = y_b;
  assign bus.busy        = s1_valid | rsp_valid_a | rsp_valid_b;

  // Operand stage and arbitration pointer.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_id    <= 1'b0;
      s1_x1    <= '0;
      s1_x2    <= '0;
      ptr      <= 1'(RR_INIT);
    end else begin
      s1_valid <= hs_a | hs_b;
      if (hs_a) begin
        s1_id <= 1'b0;
        s1_x1 <= bus.a_x1;
        s1_x2 <= bus.a_x2;
        ptr   <= 1'b1;
      end else if (hs_b) begin
        s1_id <= 1'b1;
        s1_x1 <= bus.b_x1;
        s1_x2 <= bus.b_x2;
        ptr   <= 1'b0;
      end
    end
  end

  // Response registers. The S1 write is placed after the pop so that, were
  // both to hit the same slot at one edge, the new result would win; the
  // eligibility rule keeps that from happening.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      y_a         <= '0;
      y_b         <= '0;
    end else begin
      if (rsp_valid_a && bus.a_rsp_ready) rsp_valid_a <= 1'b0;
      if (rsp_valid_b && bus.b_rsp_ready) rsp_valid_b <= 1'b0;
      if (s1_valid && !s1_id) begin
        rsp_valid_a <= 1'b1;
        y_a         <= bus.fm_y;
      end
      if (s1_valid && s1_id) begin
        rsp_valid_b <= 1'b1;
        y_b         <= bus.fm_y;
      end
    end
  end

endmodule

// File: tb/tb_fmul_arb.sv
// Self-checking bench for fmul_arb. A behavioural stand-in for the external
// multiplier returns known IEEE products for the directed vectors and a
// fixed non-commutative scramble otherwise; a per-port scoreboard queue
// holds expected results from request handshake until the response pops.
module tb_fmul_arb;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   pops_a = 0;
  int   pops_b = 0;

  logic [31:0] q_a[$];
  logic [31:0] q_b[$];

  fmul_arb_if bus ();

  fmul_arb #(.RR_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fmul_model(input logic [31:0] x1, input logic [31:0] x2);
    case ({x1, x2})
      64'h40400000_40000000: return 32'h40C00000;  //  3 * 2   =  6
      64'h3F800000_40A00000: return 32'h40A00000;  //  1 * 5   =  5
      64'hC0000000_40400000: return 32'hC0C00000;  // -2 * 3   = -6
      64'h00000000_40A00000: return 32'h00000000;  //  0 * 5   =  0
      default:               return x1 ^ {x2[15:0], x2[31:16]} ^ 32'h5A5A0F0F;
    endcase
  endfunction

  assign bus.fm_y = fmul_model(bus.fm_x1, bus.fm_x2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    bus.a_x1 = '0;
    bus.a_x2 = '0;
    bus.b_x1 = '0;
    bus.b_x2 = '0;
    bus.a_rsp_ready = 1'b1;
    bus.b_rsp_ready = 1'b1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    at_sample();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      at_sample();
      next_cycle();
    end
  endtask

  // Scoreboard monitor and slot-collision watch
  always @(negedge clk) begin
    if (rst) begin
      q_a.delete();
      q_b.delete();
    end else begin
      check("slot_collision_a", 32'(dut.s1_valid && !dut.s1_id && dut.rsp_valid_a), 32'd0);
      check("slot_collision_b", 32'(dut.s1_valid &&  dut.s1_id && dut.rsp_valid_b), 32'd0);
      if (bus.a_rsp_valid && bus.a_rsp_ready) begin
        pops_a++;
        if (q_a.size() == 0) check("sb_a_unexpected", bus.a_y, 32'hxxxxxxxx);
        else check("sb_a_y", bus.a_y, q_a.pop_front());
      end
      if (bus.b_rsp_valid && bus.b_rsp_ready) begin
        pops_b++;
        if (q_b.size() == 0) check("sb_b_unexpected", bus.b_y, 32'hxxxxxxxx);
        else check("sb_b_y", bus.b_y, q_b.pop_front());
      end
      if (bus.a_valid && bus.a_ready) q_a.push_back(fmul_model(bus.a_x1, bus.a_x2));
      if (bus.b_valid && bus.b_ready) q_b.push_back(fmul_model(bus.b_x1, bus.b_x2));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] ax1, ax2, bx1, bx2;
    int base_a, base_b;

    idle_inputs();
    rst = 1'b1;
    // Reset state
    at_sample();
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_a_rsp_valid", 32'(bus.a_rsp_valid), 32'd0);
    check("rst_b_rsp_valid", 32'(bus.b_rsp_valid), 32'd0);
    check("rst_fm_x1", bus.fm_x1, 32'd0);
    check("rst_fm_x2", bus.fm_x2, 32'd0);
    check("rst_a_y", bus.a_y, 32'd0);
    check("rst_b_y", bus.b_y, 32'd0);
    check("rst_ptr", 32'(dut.ptr), 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single op: 3 * 2
    bus.a_valid = 1'b1;
    bus.a_x1 = 32'h40400000;
    bus.a_x2 = 32'h40000000;
    at_sample();
    check("single_a_ready_c0", 32'(bus.a_ready), 32'd1);
    check("single_busy_c0", 32'(bus.busy), 32'd0);
    next_cycle();
    bus.a_valid = 1'b0;
    at_sample();
    check("single_busy_c1", 32'(bus.busy), 32'd1);
    check("single_rsp_c1", 32'(bus.a_rsp_valid), 32'd0);
    check("single_fm_x1_c1", bus.fm_x1, 32'h40400000);
    next_cycle();
    at_sample();
    check("single_rsp_c2", 32'(bus.a_rsp_valid), 32'd1);
    check("single_a_y_c2", bus.a_y, 32'h40C00000);
    check("single_busy_c2", 32'(bus.busy), 32'd1);
    next_cycle();
    at_sample();
    check("single_busy_c3", 32'(bus.busy), 32'd0);
    next_cycle();

    // Contention from reset: A wins, B follows
    do_reset();
    bus.a_valid = 1'b1; bus.a_x1 = 32'h3F800000; bus.a_x2 = 32'h40A00000;
    bus.b_valid = 1'b1; bus.b_x1 = 32'hC0000000; bus.b_x2 = 32'h40400000;
    at_sample();
    check("cont_a_ready_c0", 32'(bus.a_ready), 32'd1);
    check("cont_b_ready_c0", 32'(bus.b_ready), 32'd0);
    next_cycle();
    bus.a_valid = 1'b0;
    at_sample();
    check("cont_b_ready_c1", 32'(bus.b_ready), 32'd1);
    next_cycle();
    bus.b_valid = 1'b0;
    at_sample();
    check("cont_a_rsp_c2", 32'(bus.a_rsp_valid), 32'd1);
    check("cont_a_y_c2", bus.a_y, 32'h40A00000);
    next_cycle();
    at_sample();
    check("cont_b_rsp_c3", 32'(bus.b_rsp_valid), 32'd1);
    check("cont_b_y_c3", bus.b_y, 32'hC0C00000);
    next_cycle();
    idle_cycles(1);

    // Zero operand passes through: nonzero B result first, then 0 * 5
    bus.b_valid = 1'b1; bus.b_x1 = 32'h40400000; bus.b_x2 = 32'h40000000;
    at_sample();
    check("zero_pre_b_ready", 32'(bus.b_ready), 32'd1);
    next_cycle();
    bus.b_valid = 1'b0;
    at_sample();
    next_cycle();
    bus.b_valid = 1'b1; bus.b_x1 = 32'h00000000; bus.b_x2 = 32'h40A00000;
    at_sample();
    check("zero_pre_b_y", bus.b_y, 32'h40C00000);
    check("zero_b_ready_pop_same_cycle", 32'(bus.b_ready), 32'd1);
    next_cycle();
    bus.b_valid = 1'b0;
    at_sample();
    next_cycle();
    at_sample();
    check("zero_b_rsp", 32'(bus.b_rsp_valid), 32'd1);
    check("zero_b_y", bus.b_y, 32'h00000000);
    next_cycle();
    idle_cycles(2);

    // Fairness: both valid for 8 cycles
    do_reset();
    base_a = pops_a;
    base_b = pops_b;
    ax1 = $urandom; ax2 = $urandom; bx1 = $urandom; bx2 = $urandom;
    for (int k = 0; k < 8; k++) begin
      bus.a_valid = 1'b1; bus.a_x1 = ax1; bus.a_x2 = ax2;
      bus.b_valid = 1'b1; bus.b_x1 = bx1; bus.b_x2 = bx2;
      at_sample();
      check($sformatf("fair_a_ready_%0d", k), 32'(bus.a_ready), 32'((k % 2) == 0));
      check($sformatf("fair_b_ready_%0d", k), 32'(bus.b_ready), 32'((k % 2) == 1));
      if (bus.a_ready) begin ax1 = $urandom; ax2 = $urandom; end
      if (bus.b_ready) begin bx1 = $urandom; bx2 = $urandom; end
      next_cycle();
    end
    idle_cycles(4);
    check("fair_a_results", 32'(pops_a - base_a), 32'd4);
    check("fair_b_results", 32'(pops_b - base_b), 32'd4);

    // Backpressure on A's response; B proceeds
    do_reset();
    bus.a_rsp_ready = 1'b0;
    bus.a_valid = 1'b1; bus.a_x1 = $urandom; bus.a_x2 = $urandom;
    at_sample();
    check("bp_a_ready_c0", 32'(bus.a_ready), 32'd1);
    next_cycle();
    bus.a_x1 = $urandom; bus.a_x2 = $urandom;
    bx1 = $urandom; bx2 = $urandom;
    for (int c = 1; c < 7; c++) begin
      bus.b_valid = 1'b1; bus.b_x1 = bx1; bus.b_x2 = bx2;
      at_sample();
      check($sformatf("bp_a_ready_c%0d", c), 32'(bus.a_ready), 32'd0);
      check($sformatf("bp_b_ready_c%0d", c), 32'(bus.b_ready), 32'((c % 2) == 1));
      check($sformatf("bp_a_rsp_c%0d", c), 32'(bus.a_rsp_valid), 32'(c >= 2));
      if (bus.b_ready) begin bx1 = $urandom; bx2 = $urandom; end
      next_cycle();
    end
    bus.b_valid = 1'b0;
    bus.a_rsp_ready = 1'b1;
    at_sample();
    check("bp_a_ready_release", 32'(bus.a_ready), 32'd1);
    check("bp_a_rsp_release", 32'(bus.a_rsp_valid), 32'd1);
    next_cycle();
    idle_cycles(4);

    // Reset in the cycle after an A grant
    do_reset();
    // Move ptr to B first so the post-reset grant shows it returned to A.
    bus.a_valid = 1'b1; bus.a_x1 = $urandom; bus.a_x2 = $urandom;
    at_sample();
    check("rmf_a_ready", 32'(bus.a_ready), 32'd1);
    next_cycle();
    bus.a_valid = 1'b0;
    rst = 1'b1;
    at_sample();
    check("rmf_busy", 32'(bus.busy), 32'd0);
    check("rmf_ptr", 32'(dut.ptr), 32'd0);
    check("rmf_a_rsp_c1", 32'(bus.a_rsp_valid), 32'd0);
    next_cycle();
    at_sample();
    check("rmf_a_rsp_c2", 32'(bus.a_rsp_valid), 32'd0);
    next_cycle();
    rst = 1'b0;
    at_sample();
    check("rmf_a_rsp_c3", 32'(bus.a_rsp_valid), 32'd0);
    next_cycle();
    bus.a_valid = 1'b1; bus.a_x1 = 32'h40400000; bus.a_x2 = 32'h40000000;
    bus.b_valid = 1'b1; bus.b_x1 = $urandom;     bus.b_x2 = $urandom;
    at_sample();
    check("rmf_post_a_ready", 32'(bus.a_ready), 32'd1);
    check("rmf_post_b_ready", 32'(bus.b_ready), 32'd0);
    next_cycle();
    bus.a_valid = 1'b0;
    bus.b_valid = 1'b0;
    at_sample();
    next_cycle();
    at_sample();
    check("rmf_post_a_y", bus.a_y, 32'h40C00000);
    next_cycle();
    idle_cycles(3);

    check("end_q_a_empty", 32'(q_a.size()), 32'd0);
    check("end_q_b_empty", 32'(q_b.size()), 32'd0);
    check("end_busy", 32'(bus.busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
